// File: rtl/spi_top_module_pkg.sv
// Shared types for the SPI-memory subsystem: slave FSM states and frame opcodes.
package spi_top_module_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram.sv
// Single-port RAM decoding received frames: address registers, write, read-out.
module spi_ram
  import spi_top_module_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] i_din,
  input  logic                 i_rx_valid,
  output logic [ADDR_SIZE-1:0] o_dout,
  output logic                 o_tx_valid
);

  logic [ADDR_SIZE-1:0] mem [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [ADDR_SIZE-1:0] r_dout;
  logic                 r_tx_valid;
  logic [1:0]           w_op;

  assign w_op = i_din[ADDR_SIZE+1:ADDR_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      if (i_rx_valid) begin
        case (w_op)
          OP_WR_ADDR: r_wr_addr <= i_din[ADDR_SIZE-1:0];
          OP_RD_ADDR: r_rd_addr <= i_din[ADDR_SIZE-1:0];
          OP_RD_DATA: begin
            r_dout     <= mem[r_rd_addr];
            r_tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Storage has no reset so a preloaded image survives rst_n.
  always_ff @(posedge clk) begin
    if (i_rx_valid && w_op == OP_WR_DATA) mem[r_wr_addr] <= i_din[ADDR_SIZE-1:0];
  end

  assign o_dout     = r_dout;
  assign o_tx_valid = r_tx_valid;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: command FSM, MOSI frame receiver and MSB-first MISO transmitter.
module spi_slave
  import spi_top_module_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ss_n,
  input  logic                 i_mosi,
  input  logic                 i_tx_valid,
  input  logic [ADDR_SIZE-1:0] i_tx_data,
  output logic [ADDR_SIZE+1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_miso
);

  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(ADDR_SIZE);
  localparam logic [CW-1:0] RX_LAST = CW'(FW - 1);
  localparam logic [TW-1:0] TX_LAST = TW'(ADDR_SIZE - 1);

  state_t                r_state;
  logic [FW-1:0]         r_rx_shift;
  logic [CW-1:0]         r_rx_cnt;
  logic                  r_rx_done;
  logic [FW-1:0]         r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rd_addr_seen;
  logic [ADDR_SIZE-1:0]  r_tx_shift;
  logic [TW-1:0]         r_tx_cnt;
  logic                  r_tx_active;
  logic                  r_miso;

  // rx_valid and tx_valid are single-cycle pulses with no back-pressure:
  // the receiver of a pulse must act on the edge where it sees it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rx_shift     <= '0;
      r_rx_cnt       <= '0;
      r_rx_done      <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_tx_active    <= 1'b0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (i_ss_n) begin
        r_state     <= IDLE;
        r_rx_shift  <= '0;
        r_rx_cnt    <= '0;
        r_rx_done   <= 1'b0;
        r_tx_shift  <= '0;
        r_tx_cnt    <= '0;
        r_tx_active <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= CHK_CMD;
            r_miso  <= 1'b0;
          end
          CHK_CMD: begin
            r_miso <= 1'b0;
            if (!i_mosi)             r_state <= WRITE;
            else if (r_rd_addr_seen) r_state <= READ_DATA;
            else                     r_state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!r_rx_done) begin
              r_rx_shift <= {r_rx_shift[FW-2:0], i_mosi};
              if (r_rx_cnt == RX_LAST) begin
                r_rx_data  <= {r_rx_shift[FW-2:0], i_mosi};
                r_rx_valid <= 1'b1;
                r_rx_done  <= 1'b1;
                if (r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
              end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
              end
            end
            // First MISO bit goes out on the same edge that captures the RAM byte.
            if (r_state == READ_DATA && i_tx_valid && !r_tx_active) begin
              r_miso      <= i_tx_data[ADDR_SIZE-1];
              r_tx_shift  <= {i_tx_data[ADDR_SIZE-2:0], 1'b0};
              r_tx_cnt    <= TW'(1);
              r_tx_active <= 1'b1;
            end else if (r_state == READ_DATA && r_tx_active) begin
              r_miso     <= r_tx_shift[ADDR_SIZE-1];
              r_tx_shift <= {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
              if (r_tx_cnt == TX_LAST) begin
                r_tx_active    <= 1'b0;
                r_tx_cnt       <= '0;
                r_rd_addr_seen <= 1'b0;
              end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
              end
            end else begin
              r_miso <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_miso     = r_miso;

endmodule

// File: rtl/spi_top_module.sv
// SPI-memory subsystem top: SPI slave front-end feeding a single-port RAM.
module spi_top_module #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  logic [ADDR_SIZE+1:0] w_rx_data;
  logic                 w_rx_valid;
  logic [ADDR_SIZE-1:0] w_tx_data;
  logic                 w_tx_valid;

  spi_slave #(.ADDR_SIZE(ADDR_SIZE)) U1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ss_n     (SS_n),
    .i_mosi     (MOSI),
    .i_tx_valid (w_tx_valid),
    .i_tx_data  (w_tx_data),
    .o_rx_data  (w_rx_data),
    .o_rx_valid (w_rx_valid),
    .o_miso     (MISO)
  );

  spi_ram #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) U2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_din      (w_rx_data),
    .i_rx_valid (w_rx_valid),
    .o_dout     (w_tx_data),
    .o_tx_valid (w_tx_valid)
  );

endmodule

// File: tb/tb_spi_top_module.sv
// Self-checking bench for spi_top_module: directed frames plus randomized traffic vs a memory model.
module tb_spi_top_module;
  import spi_top_module_pkg::*;

  logic clk;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;

  spi_top_module #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // reference model
  logic [7:0] m_mem [0:255];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  logic       m_seen;
  logic [7:0] known_q [$];
  logic [7:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_wr_addr"}, dut.U2.r_wr_addr, m_wr);
    chk({tag, "_rd_addr"}, dut.U2.r_rd_addr, m_rd);
    chk({tag, "_seen"}, dut.U1.r_rd_addr_seen, m_seen);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    m_wr = 8'h00; m_rd = 8'h00; m_seen = 1'b0;
    @(negedge clk);
    chk("rst_miso", MISO, 0);
    chk("rst_state", dut.U1.r_state, IDLE);
    check_regs("rst");
    rst_n = 1'b1;
  endtask

  // Drives one SS_n-low transaction: select cycle, command bit, nbits of frame.
  // nbits < 10 aborts reception; tx_bits < 8 aborts a read-data transmit.
  task automatic send_frame(input logic cmd, input logic [9:0] frame, input int nbits, input int tx_bits);
    state_t     st;
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] got;
    logic [7:0] e;
    bit         tx;
    st = cmd ? (m_seen ? READ_DATA : READ_ADD) : WRITE;
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk); MOSI = cmd;
    @(negedge clk);
    chk("cmd_state", dut.U1.r_state, st);
    MOSI = frame[9];
    for (int i = 1; i < nbits; i++) begin
      @(negedge clk); MOSI = frame[9-i];
    end
    if (nbits < 10) begin
      @(negedge clk); SS_n = 1'b1;
      @(negedge clk);
      chk("abort_state", dut.U1.r_state, IDLE);
      chk("abort_miso", MISO, 0);
      check_regs("abort");
      return;
    end
    op = frame[9:8];
    d  = frame[7:0];
    tx = (st == READ_DATA) && (op == OP_RD_DATA);
    if (st == READ_ADD) m_seen = 1'b1;
    case (op)
      OP_WR_ADDR: m_wr = d;
      OP_WR_DATA: m_mem[m_wr] = d;
      OP_RD_ADDR: m_rd = d;
      default: if (tx) exp_q.push_back(m_mem[m_rd]);
    endcase
    if (tx) begin
      @(negedge clk);
      @(negedge clk);
      got = '0;
      for (int i = 0; i < tx_bits; i++) begin
        @(negedge clk); got[7-i] = MISO;
      end
      SS_n = 1'b1;
      @(negedge clk);
      chk("miso_after", MISO, 0);
      chk("tx_end_state", dut.U1.r_state, IDLE);
      e = exp_q.pop_front();
      if (tx_bits == 8) begin
        m_seen = 1'b0;
        chk("miso_byte", got, e);
      end else begin
        chk("miso_partial", got >> (8 - tx_bits), e >> (8 - tx_bits));
      end
    end else begin
      @(negedge clk); SS_n = 1'b1;
      @(negedge clk);
    end
    check_regs("frame");
    if (op == OP_WR_DATA) chk("mem_write", dut.U2.mem[m_wr], m_mem[m_wr]);
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] v);
    send_frame(1'b0, {OP_WR_ADDR, a}, 10, 8);
    send_frame(1'b0, {OP_WR_DATA, v}, 10, 8);
    known_q.push_back(a);
  endtask

  task automatic read_byte(input logic [7:0] a);
    send_frame(1'b1, {OP_RD_ADDR, a}, 10, 8);
    send_frame(1'b1, {OP_RD_DATA, 8'($urandom)}, 10, 8);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] v;
    int         r;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    m_wr = 8'h00; m_rd = 8'h00; m_seen = 1'b0;
    @(negedge clk);
    chk("init_miso", MISO, 0);
    chk("init_state", dut.U1.r_state, IDLE);
    check_regs("init");
    rst_n = 1'b1;

    // directed frames
    send_frame(1'b0, 10'b00_1100_1011, 10, 8);
    chk("dir_wr_addr", dut.U2.r_wr_addr, 8'hCB);
    send_frame(1'b0, 10'b01_1111_0011, 10, 8);
    chk("dir_mem_cb", dut.U2.mem[8'hCB], 8'hF3);
    known_q.push_back(8'hCB);
    send_frame(1'b1, 10'b10_1100_1011, 10, 8);
    chk("dir_seen_set", dut.U1.r_rd_addr_seen, 1);
    send_frame(1'b1, 10'b11_0000_1111, 10, 8);
    chk("dir_seen_clr", dut.U1.r_rd_addr_seen, 0);
    send_frame(1'b1, 10'b10_1110_1011, 10, 8);
    chk("dir_rd_addr", dut.U2.r_rd_addr, 8'hEB);
    send_frame(1'b0, 10'b01_0101_0101, 5, 8);
    chk("dir_abort_mem", dut.U2.mem[8'hCB], 8'hF3);

    // read-data with only a reset rd_addr behind it
    write_byte(8'h00, 8'h5A);
    do_reset();
    send_frame(1'b1, {OP_RD_DATA, 8'h00}, 10, 8);
    send_frame(1'b1, {OP_RD_DATA, 8'h00}, 10, 8);

    // transmit aborted mid-byte keeps the read address armed
    send_frame(1'b1, {OP_RD_ADDR, 8'hCB}, 10, 8);
    send_frame(1'b1, {OP_RD_DATA, 8'h00}, 10, 3);
    send_frame(1'b1, {OP_RD_DATA, 8'h00}, 10, 8);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: begin
          a = 8'($urandom); v = 8'($urandom);
          write_byte(a, v);
        end
        1: begin
          a = known_q[$urandom_range(0, known_q.size() - 1)];
          read_byte(a);
        end
        2: begin
          send_frame(1'($urandom), 10'($urandom), $urandom_range(1, 9), 8);
        end
        default: begin
          v = 8'($urandom);
          send_frame(1'b0, {2'($urandom_range(0, 2)), v}, 10, 8);
          if (dut.U2.r_wr_addr == m_wr) known_q.push_back(m_wr);
        end
      endcase
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
